// File: rtl/shiftin_pkg.sv
// rtl/shiftin_pkg.sv - shared FSM state type and default parameters for the 74HC165 reader
package shiftin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_POLL_PERIOD = 0;

endpackage

// File: rtl/shiftin_sync.sv
// rtl/shiftin_sync.sv - two-flop synchronizer for the asynchronous serial data input
module shiftin_sync (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/shiftin.sv
// rtl/shiftin.sv - reads a chain of 74HC165 shift registers on request or on a poll timer
module shiftin
    import shiftin_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD
) (
    input  logic             clk_25MHz,
    input  logic             resetn,
    input  logic             start,
    output logic             shiftin_clock,
    output logic             shiftin_load,
    input  logic             shiftin_data,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             data_changed,
    output logic             busy
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int IDX_W  = $clog2(WIDTH);
    localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

    state_t             state_q, state_d;
    logic               load_q, load_d;
    logic               sclk_q, sclk_d;
    logic               busy_q, busy_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               changed_q, changed_d;

    logic sdata;
    logic div_last;
    logic sample;
    logic frame_end;
    logic poll_expire;
    logic trigger;

    shiftin_sync u_sync (
        .clk_i    (clk_25MHz),
        .resetn_i (resetn),
        .d_i      (shiftin_data),
        .q_o      (sdata)
    );

    assign div_last    = (div_q == DIV_LAST);
    assign sample      = (state_q == SHIFT_LO) && div_last;
    assign frame_end   = sample && (idx_q == IDX_LAST);
    assign poll_expire = (POLL_PERIOD > 0) && (state_q == IDLE) && (poll_q == POLL_LAST);
    assign trigger     = start || poll_expire;

    // State and pin registers: pins are registered so CP/PL never glitch on state decode.
    always_ff @(posedge clk_25MHz) begin
        if (!resetn) begin
            state_q <= IDLE;
            load_q  <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (trigger)  state_d = LOAD;
            LOAD:     if (div_last) state_d = SHIFT_LO;
            SHIFT_LO: if (div_last) state_d = (idx_q == IDX_LAST) ? DONE : SHIFT_HI;
            SHIFT_HI: if (div_last) state_d = SHIFT_LO;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        load_d = (state_d != LOAD);
        sclk_d = (state_d == SHIFT_HI);
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        div_d = '0;
        if ((state_q == LOAD || state_q == SHIFT_LO || state_q == SHIFT_HI) && !div_last) begin
            div_d = div_q + 1'b1;
        end
        idx_d = idx_q;
        if (state_q == IDLE) begin
            idx_d = '0;
        end else if (state_q == SHIFT_HI && div_last) begin
            idx_d = idx_q + 1'b1;
        end
        // Poll timer only runs while idle, so it restarts from zero on every IDLE entry.
        poll_d = '0;
        if ((POLL_PERIOD > 0) && (state_q == IDLE) && !poll_expire) begin
            poll_d = poll_q + 1'b1;
        end
        shift_d   = sample ? {shift_q[WIDTH-2:0], sdata} : shift_q;
        data_d    = frame_end ? shift_d : data_q;
        valid_d   = frame_end;
        changed_d = frame_end && (shift_d != data_q);
    end

    always_ff @(posedge clk_25MHz) begin
        if (!resetn) begin
            div_q     <= '0;
            idx_q     <= '0;
            poll_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            poll_q    <= poll_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign shiftin_clock = sclk_q;
    assign shiftin_load  = load_q;
    assign busy          = busy_q;
    assign data          = data_q;
    assign data_valid    = valid_q;
    assign data_changed  = changed_q;

endmodule

// File: tb/tb_shiftin.sv
// tb/tb_shiftin.sv - scoreboard bench for shiftin with zero-delay 74HC165 chain models
module tb_shiftin;

    typedef struct {
        logic [15:0] data;
        logic        chg;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // DUT a: on-demand reads; DUT p: auto-poll; DUT w: two chained registers
    logic        rstn_a = 1'b0, rstn_pw = 1'b0;
    logic        start_a = 1'b0, start_p = 1'b0, start_w = 1'b0;
    logic        sclk_a, load_a, valid_a, chg_a, busy_a;
    logic        sclk_p, load_p, valid_p, chg_p, busy_p;
    logic        sclk_w, load_w, valid_w, chg_w, busy_w;
    logic [7:0]  data_a, data_p;
    logic [15:0] data_w;
    logic [7:0]  par_a = 8'hA5, par_p = 8'hA5;
    logic [15:0] par_w = 16'h1234;
    logic [7:0]  sr_a = '0, sr_p = '0;
    logic [15:0] sr_w = '0;

    always @(posedge sclk_a or negedge load_a) if (!load_a) sr_a <= par_a; else sr_a <= {sr_a[6:0], 1'b0};
    always @(posedge sclk_p or negedge load_p) if (!load_p) sr_p <= par_p; else sr_p <= {sr_p[6:0], 1'b0};
    always @(posedge sclk_w or negedge load_w) if (!load_w) sr_w <= par_w; else sr_w <= {sr_w[14:0], 1'b0};

    shiftin #(.WIDTH(8), .CLK_DIV(4), .POLL_PERIOD(0)) dut_a (
        .clk_25MHz(clk), .resetn(rstn_a), .start(start_a), .shiftin_clock(sclk_a),
        .shiftin_load(load_a), .shiftin_data(sr_a[7]), .data(data_a), .data_valid(valid_a),
        .data_changed(chg_a), .busy(busy_a));

    shiftin #(.WIDTH(8), .CLK_DIV(4), .POLL_PERIOD(100)) dut_p (
        .clk_25MHz(clk), .resetn(rstn_pw), .start(start_p), .shiftin_clock(sclk_p),
        .shiftin_load(load_p), .shiftin_data(sr_p[7]), .data(data_p), .data_valid(valid_p),
        .data_changed(chg_p), .busy(busy_p));

    shiftin #(.WIDTH(16), .CLK_DIV(4), .POLL_PERIOD(0)) dut_w (
        .clk_25MHz(clk), .resetn(rstn_pw), .start(start_w), .shiftin_clock(sclk_w),
        .shiftin_load(load_w), .shiftin_data(sr_w[15]), .data(data_w), .data_valid(valid_w),
        .data_changed(chg_w), .busy(busy_w));

    exp_t q_a[$], q_p[$], q_w[$];

    int lc_a = 0, ec_a = 0, lc_p = 0, ec_p = 0, lc_w = 0, ec_w = 0;
    logic ps_a = 1'b0, ps_p = 1'b0, ps_w = 1'b0;
    int n_p = 0, last_p = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rstn_a) begin
            lc_a = 0; ec_a = 0;
        end else begin
            if (!load_a) lc_a++;
            if (sclk_a && !ps_a) ec_a++;
            if (chg_a) chk("a_changed_only_with_valid", valid_a, 1);
            if (valid_a) begin
                chk("a_expected_frame_pending", q_a.size() > 0, 1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk("a_data", data_a, e.data);
                    chk("a_changed", chg_a, e.chg);
                    chk("a_valid_cycle", cyc, e.cyc);
                    chk("a_load_low_cycles", lc_a, 4);
                    chk("a_clock_rises", ec_a, 7);
                end
                lc_a = 0; ec_a = 0;
            end
        end
        ps_a = sclk_a;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rstn_pw) begin
            lc_p = 0; ec_p = 0;
        end else begin
            if (!load_p) lc_p++;
            if (sclk_p && !ps_p) ec_p++;
            if (chg_p) chk("p_changed_only_with_valid", valid_p, 1);
            if (valid_p) begin
                chk("p_expected_frame_pending", q_p.size() > 0, 1);
                if (q_p.size() > 0) begin
                    e = q_p.pop_front();
                    chk("p_data", data_p, e.data);
                    chk("p_changed", chg_p, e.chg);
                    if (e.cyc >= 0) chk("p_valid_cycle", cyc, e.cyc);
                    chk("p_load_low_cycles", lc_p, 4);
                    chk("p_clock_rises", ec_p, 7);
                end
                lc_p = 0; ec_p = 0;
                last_p = cyc;
                n_p++;
            end
        end
        ps_p = sclk_p;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rstn_pw) begin
            lc_w = 0; ec_w = 0;
        end else begin
            if (!load_w) lc_w++;
            if (sclk_w && !ps_w) ec_w++;
            if (valid_w) begin
                chk("w_expected_frame_pending", q_w.size() > 0, 1);
                if (q_w.size() > 0) begin
                    e = q_w.pop_front();
                    chk("w_data", data_w, e.data);
                    chk("w_changed", chg_w, e.chg);
                    chk("w_valid_cycle", cyc, e.cyc);
                    chk("w_load_low_cycles", lc_w, 4);
                    chk("w_clock_rises", ec_w, 15);
                end
                lc_w = 0; ec_w = 0;
            end
        end
        ps_w = sclk_w;
    end

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain_a();
        for (int i = 0; i < 300 && q_a.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("a_frame_timeout", q_a.size(), 0);
    endtask

    task automatic wait_p(input int k);
        for (int i = 0; i < 500 && n_p < k; i++) begin
            @(posedge clk); #1;
        end
        chk("p_frame_timeout", n_p >= k, 1);
    endtask

    task automatic pulse_a(output int t);
        start_a = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn_pw = 1'b1;
        fork
            begin : seq_a
                int t;
                @(negedge clk);
                chk("a_rst_load", load_a, 1);
                chk("a_rst_clock", sclk_a, 0);
                chk("a_rst_busy", busy_a, 0);
                chk("a_rst_data", data_a, 0);
                chk("a_rst_valid", valid_a, 0);
                @(posedge clk); #1 rstn_a = 1'b1;
                repeat (3) @(posedge clk); #1;
                q_a.push_back('{16'h00A5, 1'b1, cyc + 65});
                pulse_a(t);
                @(negedge clk);
                chk("a_busy_in_load", busy_a, 1);
                chk("a_load_active", load_a, 0);
                drain_a();
                repeat (5) @(posedge clk); #1;
                q_a.push_back('{16'h00A5, 1'b0, cyc + 65});
                pulse_a(t);
                drain_a();
                repeat (5) @(posedge clk); #1;
                par_a = 8'h5A;
                q_a.push_back('{16'h005A, 1'b1, cyc + 65});
                pulse_a(t);
                step_to(t + 10);
                chk("a_busy_mid_frame", busy_a, 1);
                start_a = 1'b1;
                @(posedge clk); #1 start_a = 1'b0;
                drain_a();
                repeat (80) @(posedge clk); #1;
                chk("a_idle_after_ignored_start", busy_a, 0);
                pulse_a(t);
                step_to(t + 10);
                rstn_a = 1'b0;
                @(negedge clk);
                chk("a_in_shift_hi", sclk_a, 1);
                @(posedge clk); #1 rstn_a = 1'b1;
                @(negedge clk);
                chk("a_abort_load", load_a, 1);
                chk("a_abort_clock", sclk_a, 0);
                chk("a_abort_busy", busy_a, 0);
                chk("a_abort_data", data_a, 0);
                chk("a_abort_valid", valid_a, 0);
                repeat (80) @(posedge clk); #1;
                par_a = 8'hC3;
                q_a.push_back('{16'h00C3, 1'b1, cyc + 65});
                pulse_a(t);
                drain_a();
            end
            begin : seq_w
                int t;
                repeat (4) @(posedge clk); #1;
                q_w.push_back('{16'h1234, 1'b1, cyc + 129});
                start_w = 1'b1;
                t = cyc;
                @(posedge clk); #1 start_w = 1'b0;
                for (int i = 0; i < 400 && q_w.size() != 0; i++) begin
                    @(posedge clk); #1;
                end
                chk("w_frame_timeout", q_w.size(), 0);
                chk("w_idle_after_frame", busy_w, 0);
            end
            begin : seq_p
                int d;
                q_p.push_back('{16'h00A5, 1'b1, -1});
                wait_p(1);
                d = last_p;
                q_p.push_back('{16'h00A5, 1'b0, d + 165});
                wait_p(2);
                d = last_p;
                par_p = 8'h3C;
                q_p.push_back('{16'h003C, 1'b1, d + 165});
                wait_p(3);
                d = last_p;
                q_p.push_back('{16'h003C, 1'b0, d + 165});
                step_to(d + 100);
                start_p = 1'b1;
                @(posedge clk); #1 start_p = 1'b0;
                wait_p(4);
                repeat (80) @(posedge clk); #1;
                chk("p_queue_empty", q_p.size(), 0);
            end
        join
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
